fifo_stream_reader: RTL and testbench
=====================================

Name: fifo_stream_reader

Overview:
- Read-side master for the team's synchronous FIFO. It drives the FIFO read port, absorbs the FIFO's one-cycle registered read latency, and presents the data as a valid/ready stream at up to one word per clock.
- A 2-entry prefetch/skid buffer decouples downstream backpressure from the FIFO read timing.
- Sits between the FIFO and consumers such as the PWM duty loader or a serial transmitter.

Parameters:
- DATA_WIDTH, 8, width of the FIFO word and of m_data.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- fifo_rd_en  out  1  FIFO read enable; FIFO drives fifo_dout one cycle after an accepted read.
- fifo_dout  in  DATA_WIDTH  FIFO registered read data.
- fifo_empty  in  1  FIFO empty flag.
- fifo_full  in  1  FIFO full flag.
- fifo_wr_en  in  1  FIFO write enable, monitored only.
- flush  in  1  synchronous discard of buffered and in-flight data.
- m_valid  out  1  stream data valid.
- m_data  out  DATA_WIDTH  stream data, the head of the buffer.
- m_ready  in  1  downstream accept.
- buf_count  out  2  number of words held in the buffer (0..2).

Behaviour:
- Reset: rst_n is asynchronous and active-low; the clock is clk. While rst_n is low:
  - fifo_rd_en=0, m_valid=0, m_data=0, buf_count=0, inflight=0.
  - Buffer contents are cleared to 0.
  - Reset mid-operation drops all buffered and in-flight words; no word is delivered after reset release until a new read completes.
- FIFO acceptance rule: the FIFO ignores a read when it is empty, or when it is full and a write is asserted in the same cycle.
  - fifo_rd_en is combinational and equals want_read && !fifo_empty && !(fifo_full && fifo_wr_en) && !flush.
  - Every asserted fifo_rd_en is therefore an accepted read.
- Credit rule:
  - pop = m_valid && m_ready.
  - want_read = (buf_count + inflight - pop) < 2.
  - The buffer can never overflow.
- In-flight tracking:
  - inflight <= fifo_rd_en (registered).
  - In the cycle where inflight=1, fifo_dout is written into the buffer at its tail on that clock edge.
- Buffer:
  - 2-entry circular buffer with 1-bit head and tail pointers plus buf_count.
  - m_valid = (buf_count != 0); m_data = entry[head].
  - Push and pop in the same cycle: buf_count is unchanged and both pointers advance.
  - Pointers wrap 1 -> 0.
- Latency and throughput:
  - With the FIFO non-empty and the buffer empty, fifo_rd_en is high in cycle N, data is captured at the end of cycle N+1, and m_valid is high in cycle N+2.
  - Steady-state throughput with m_ready held at 1 is one word per cycle, with no bubbles.
- Backpressure:
  - m_data and m_valid are held stable while m_valid=1 and m_ready=0.
  - Reads stop once buf_count + inflight reaches 2.
- Ordering: words leave in exactly FIFO order; none are lost or duplicated.
- Flush, while high:
  - fifo_rd_en=0.
  - On the clock edge: buf_count<=0, head<=tail, and the capture of any in-flight word is suppressed.
  - m_valid is 0 in the cycle after flush.
  - Words already read from the FIFO are discarded; this is intended.
- Empty toggling: if fifo_empty rises, reads stop the same cycle. A read issued in the previous cycle still completes.

Test Plan:
- Reset, then FIFO loaded with 0x11,0x22,0x33 and m_ready=1 -> fifo_rd_en high in 3 consecutive cycles; m_valid high for 3 consecutive cycles starting 2 cycles after the first read, carrying 0x11,0x22,0x33; then m_valid=0 and fifo_rd_en=0.
- FIFO holds 5 words, m_ready=0 -> exactly 2 reads issued; buf_count=2; m_data=first word held stable. Raise m_ready -> all 5 words delivered in order with no gaps after the first.
- FIFO full, writer asserting fifo_wr_en every cycle -> fifo_rd_en stays 0 while full && wr_en; no phantom words appear. Once the writer deasserts, reads resume and the data sequence stays intact.
- m_ready toggling 1,0,1,0 with a 16-word incrementing stream 0x00..0x0F -> output sequence is exactly 0x00..0x0F; buf_count never exceeds 2.
- Flush pulse while buf_count=2 and inflight=1 -> next cycle m_valid=0, buf_count=0; the next delivered word is the FIFO word after the discarded ones.
- rst_n pulled low asynchronously mid-stream -> m_valid and fifo_rd_en drop immediately without a clock edge; after release, no stale data is output before new reads complete.

Source files
------------

// File: rtl/fifo_stream_reader_if.sv
// rtl/fifo_stream_reader_if.sv - FIFO read-port and output-stream bundle for fifo_stream_reader
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  fifo_wr_en;
  logic                  flush;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;
  logic [1:0]            buf_count;

  modport master (
    output fifo_rd_en,
    input  fifo_dout,
    input  fifo_empty,
    input  fifo_full,
    input  fifo_wr_en,
    input  flush,
    output m_valid,
    output m_data,
    input  m_ready,
    output buf_count
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_dout,
    output fifo_empty,
    output fifo_full,
    output fifo_wr_en,
    output flush,
    input  m_valid,
    input  m_data,
    output m_ready,
    input  buf_count
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO read master with 2-entry skid buffer presenting a valid/ready stream
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  fifo_stream_reader_if.master bus
);

  logic [DATA_WIDTH-1:0] entry [2];
  logic                  head;
  logic                  tail;
  logic                  inflight;
  logic [1:0]            count;

  logic                  pop;
  logic                  push;
  logic                  want_read;
  logic                  rd_en;
  logic [2:0]            occ_next;

  // Credit counts words already buffered plus the one still in the FIFO pipeline,
  // so a read is only issued when its data is guaranteed a free slot.
  always_comb begin
    pop       = (count != 2'd0) && bus.m_ready;
    push      = inflight && !bus.flush;
    occ_next  = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    want_read = (occ_next < 3'd2);
    rd_en     = rst_n && want_read && !bus.fifo_empty
                && !(bus.fifo_full && bus.fifo_wr_en) && !bus.flush;
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = (count != 2'd0);
  assign bus.m_data     = entry[head];
  assign bus.buf_count  = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry[0] <= '0;
      entry[1] <= '0;
      head     <= 1'b0;
      tail     <= 1'b0;
      count    <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (bus.flush) begin
        // Realign head to tail so the next captured word becomes the head.
        count <= 2'd0;
        head  <= tail;
      end else begin
        if (push) begin
          entry[tail] <= bus.fifo_dout;
          tail        <= ~tail;
        end
        if (pop) begin
          head <= ~head;
        end
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - self-checking bench for fifo_stream_reader with a FIFO model and scoreboard
module tb_fifo_stream_reader;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();
  fifo_stream_reader #(.DATA_WIDTH(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  int n_pop    = 0;
  int n_rd     = 0;

  logic [DW-1:0] sb [$];

  // Behavioural FIFO with registered read data
  logic [DW-1:0] fm [DEPTH];
  int            fr = 0;
  int            fw = 0;
  int            fc = 0;
  logic [DW-1:0] fdout = '0;
  logic          wr_req = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          m_rd;
  logic          m_wr;

  logic tbl_mode = 1'b0;
  logic tbl_empty = 1'b1;
  logic tbl_full = 1'b0;
  logic tbl_wr = 1'b0;

  assign bus.fifo_dout  = fdout;
  assign bus.fifo_empty = tbl_mode ? tbl_empty : (fc == 0);
  assign bus.fifo_full  = tbl_mode ? tbl_full  : (fc == DEPTH);
  assign bus.fifo_wr_en = tbl_mode ? tbl_wr    : wr_req;

  always @(posedge clk) begin
    m_rd = !tbl_mode && bus.fifo_rd_en && (fc != 0);
    m_wr = !tbl_mode && wr_req && (fc != DEPTH);
    if (m_rd) begin
      fdout <= fm[fr];
      fr    <= (fr + 1) % DEPTH;
      n_rd++;
    end
    if (m_wr) begin
      fm[fw] <= wr_data;
      fw     <= (fw + 1) % DEPTH;
      sb.push_back(wr_data);
    end
    fc <= fc + (m_wr ? 1 : 0) - (m_rd ? 1 : 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rebuild_sb();
    sb.delete();
    for (int i = 0; i < fc; i++) sb.push_back(fm[(fr + i) % DEPTH]);
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    bus.m_ready = 1'b1;
    k = 0;
    while ((sb.size() != 0 || fc != 0) && k < budget) begin
      tick();
      k++;
    end
    tick();
    check($sformatf("%s_drained", name), sb.size(), 0);
  endtask

  // Output monitor: scoreboard pops, hold stability, occupancy bound
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] exp_word;
  always @(negedge clk) begin
    if (rst_n && !tbl_mode) begin
      check("buf_count_le2", (bus.buf_count <= 2'd2), 1);
      if (prev_hold && bus.m_valid) check("hold_stable", bus.m_data, prev_data);
      if (bus.m_valid && bus.m_ready) begin
        n_pop++;
        check("sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_word = sb.pop_front();
          check("stream_data", bus.m_data, exp_word);
        end
      end
      prev_hold = bus.m_valid && !bus.m_ready;
      prev_data = bus.m_data;
    end else begin
      prev_hold = 1'b0;
    end
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  typedef struct {
    logic empty;
    logic full;
    logic wr;
    logic fl;
    logic exp_rd;
    logic exp_valid;
  } vec_t;

  initial begin
    vec_t tbl [8];
    logic rd_t [12];
    logic v_t  [12];
    int   base;
    int   first;
    int   last;
    int   nxt;
    bit   found;

    tbl[0] = '{empty: 1, full: 0, wr: 0, fl: 0, exp_rd: 0, exp_valid: 0};
    tbl[1] = '{empty: 0, full: 0, wr: 0, fl: 0, exp_rd: 1, exp_valid: 0};
    tbl[2] = '{empty: 0, full: 1, wr: 0, fl: 0, exp_rd: 1, exp_valid: 0};
    tbl[3] = '{empty: 0, full: 1, wr: 1, fl: 0, exp_rd: 0, exp_valid: 0};
    tbl[4] = '{empty: 0, full: 0, wr: 1, fl: 0, exp_rd: 1, exp_valid: 0};
    tbl[5] = '{empty: 0, full: 0, wr: 0, fl: 1, exp_rd: 0, exp_valid: 0};
    tbl[6] = '{empty: 1, full: 1, wr: 1, fl: 1, exp_rd: 0, exp_valid: 0};
    tbl[7] = '{empty: 0, full: 1, wr: 1, fl: 1, exp_rd: 0, exp_valid: 0};

    bus.flush   = 1'b0;
    bus.m_ready = 1'b0;
    rst_n       = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_rd_en", bus.fifo_rd_en, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_buf_count", bus.buf_count, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Read-enable gating table with an empty buffer
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      tbl_mode  = 1'b1;
      tbl_empty = tbl[i].empty;
      tbl_full  = tbl[i].full;
      tbl_wr    = tbl[i].wr;
      bus.flush = tbl[i].fl;
      #1;
      check($sformatf("tbl%0d_rd_en", i), bus.fifo_rd_en, tbl[i].exp_rd);
      check($sformatf("tbl%0d_m_valid", i), bus.m_valid, tbl[i].exp_valid);
      tbl_mode  = 1'b0;
      bus.flush = 1'b0;
    end

    // Three words, m_ready high: read timing and first-word latency
    tick();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      wr_req  = (i < 3);
      wr_data = (i == 0) ? 8'h11 : (i == 1) ? 8'h22 : 8'h33;
      @(negedge clk);
      rd_t[i] = bus.fifo_rd_en;
      v_t[i]  = bus.m_valid;
    end
    for (int i = 0; i < 12; i++) begin
      check($sformatf("t1_rd_%0d", i), rd_t[i], (i >= 1 && i <= 3));
      check($sformatf("t1_valid_%0d", i), v_t[i], (i >= 3 && i <= 5));
    end
    drain("t1", 20);

    // Backpressure: five words, m_ready low
    bus.m_ready = 1'b0;
    base = n_rd;
    for (int i = 0; i < 5; i++) begin
      tick();
      wr_req  = 1'b1;
      wr_data = 8'hA0 + 8'(i);
    end
    tick();
    wr_req = 1'b0;
    repeat (4) tick();
    check("t2_reads", n_rd - base, 2);
    check("t2_buf_count", bus.buf_count, 2);
    check("t2_head", bus.m_data, 8'hA0);
    base = n_pop;
    first = -1;
    last  = -1;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.m_valid) begin
        if (first < 0) first = i;
        last = i;
      end
    end
    tick();
    check("t2_first", first, 0);
    check("t2_last", last, 4);
    check("t2_popped", n_pop - base, 5);
    drain("t2", 20);

    // FIFO full with writer holding wr_en: reads must stay off
    bus.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      wr_req  = 1'b1;
      wr_data = 8'hB0 + 8'(i);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      wr_req  = 1'b1;
      wr_data = 8'hEE;
      if (i == 2) bus.m_ready = 1'b1;
      @(negedge clk);
      check($sformatf("t3_rd_blocked_%0d", i), bus.fifo_rd_en, 0);
      if (i == 7) check("t3_no_phantom", bus.m_valid, 0);
    end
    tick();
    wr_req = 1'b0;
    drain("t3", 40);

    // Sixteen-word incrementing stream with m_ready toggling
    base = n_pop;
    nxt  = 0;
    for (int k = 0; k < 300 && (nxt < 16 || sb.size() != 0 || fc != 0); k++) begin
      tick();
      bus.m_ready = (k % 2 == 0);
      if (nxt < 16 && fc < DEPTH) begin
        wr_req  = 1'b1;
        wr_data = 8'(nxt);
        nxt++;
      end else begin
        wr_req = 1'b0;
      end
    end
    tick();
    wr_req = 1'b0;
    check("t4_popped", n_pop - base, 16);
    drain("t4", 20);

    // Flush with a full buffer, then flush with a word in flight
    bus.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      wr_req  = 1'b1;
      wr_data = 8'hC0 + 8'(i);
    end
    tick();
    wr_req = 1'b0;
    repeat (3) tick();
    check("t5_full_buf", bus.buf_count, 2);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    rebuild_sb();
    @(negedge clk);
    check("t5_valid_after_flush", bus.m_valid, 0);
    check("t5_count_after_flush", bus.buf_count, 0);
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    rebuild_sb();
    check("t5_fifo_left", fc, 3);
    @(negedge clk);
    check("t5_inflight_dropped", bus.m_valid, 0);
    check("t5_count_inflight_dropped", bus.buf_count, 0);
    tick();
    bus.m_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus.m_valid) begin
        found = 1'b1;
        check("t5_next_word", bus.m_data, 8'hC3);
      end
    end
    check("t5_word_delivered", found, 1);
    drain("t5", 20);

    // Asynchronous reset mid-stream
    bus.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      wr_req  = 1'b1;
      wr_data = 8'hE0 + 8'(i);
    end
    tick();
    wr_req = 1'b0;
    repeat (2) tick();
    bus.m_ready = 1'b1;
    tick();
    #2;
    check("t6_pre_valid", bus.m_valid, 1);
    check("t6_pre_rd_en", bus.fifo_rd_en, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", bus.m_valid, 0);
    check("t6_rst_rd_en", bus.fifo_rd_en, 0);
    check("t6_rst_count", bus.buf_count, 0);
    check("t6_rst_data", bus.m_data, 0);
    repeat (2) @(posedge clk);
    #1;
    rebuild_sb();
    check("t6_fifo_left", fc, 3);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_no_stale_0", bus.m_valid, 0);
    @(negedge clk);
    check("t6_no_stale_1", bus.m_valid, 0);
    drain("t6", 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
